// File: rtl/risc_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
//
// Contents:
//   - RV32I major opcode constants
//   - ctrl_state_t : controller FSM states (TRAP only with ILLEGAL_TRAP_EN)
//   - alu_op_t     : ALU operation select
//   - wb_src_t     : register-file write-back source
//   - mem_size_t   : data memory access size
//   - instr_cls_t  : coarse instruction class used to steer the FSM
//   - decode_t     : bundle produced by mc_decode
//   - funct_to_alu : funct3/alt-bit to ALU operation mapping
//
// Configuration macro: ILLEGAL_TRAP_EN (adds the TRAP state).
package risc_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP
`endif
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_src_t;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } mem_size_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE
    } instr_cls_t;

    typedef struct packed {
        instr_cls_t cls;
        alu_op_t    alu_op;
        logic       op1_sel;   // 0 = rs1, 1 = pc
        logic       op2_sel;   // 0 = rs2, 1 = immediate
        wb_src_t    wb_src;
        mem_size_t  size;
        logic       zero_ext;
        logic       illegal;
    } decode_t;

    // alt selects SUB over ADD and SRA over SRL (instr bit 30).
    function automatic alu_op_t funct_to_alu(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for mc_control.
//
// Ports:
//   instr  in   32        instruction word from the external IR
//   dec    out  decode_t  class, ALU controls, write-back source, memory
//                         size/extension and an illegal-encoding flag
//
// Unsupported opcodes and funct7 values are flagged illegal and decoded
// as an ADDI-class ALU operation (rs1 + imm, written back), so the FSM
// has a well-defined path whether or not trapping is enabled.
module mc_decode
    import risc_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec.cls      = CLS_ALU;
        dec.alu_op   = ALU_ADD;
        dec.op1_sel  = 1'b0;
        dec.op2_sel  = 1'b1;
        dec.wb_src   = WB_ALU;
        dec.size     = MEM_WORD;
        dec.zero_ext = 1'b0;
        dec.illegal  = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00) begin
                    dec.op2_sel = 1'b0;
                    dec.alu_op  = funct_to_alu(funct3, 1'b0);
                end else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    dec.op2_sel = 1'b0;
                    dec.alu_op  = funct_to_alu(funct3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // funct7 only exists for the shift-immediate forms.
                if (funct3 == 3'd1 && funct7 != 7'h00) begin
                    dec.illegal = 1'b1;
                end else if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = funct_to_alu(funct3, (funct3 == 3'd5) && funct7[5]);
                end
            end
            OPC_LUI: begin
                dec.alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                dec.op1_sel = 1'b1;
            end
            OPC_JAL: begin
                dec.cls     = CLS_JUMP;
                dec.op1_sel = 1'b1;
                dec.wb_src  = WB_PC4;
            end
            OPC_JALR: begin
                dec.cls    = CLS_JUMP;
                dec.wb_src = WB_PC4;
            end
            OPC_BRANCH: begin
                // ALU forms the target pc + imm; the comparator is external.
                dec.cls     = CLS_BRANCH;
                dec.op1_sel = 1'b1;
            end
            OPC_LOAD: begin
                dec.cls      = CLS_LOAD;
                dec.wb_src   = WB_MEM;
                dec.zero_ext = funct3[2];
            end
            OPC_STORE: begin
                dec.cls = CLS_STORE;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
            case (funct3[1:0])
                2'd0:    dec.size = MEM_BYTE;
                2'd1:    dec.size = MEM_HALF;
                default: dec.size = MEM_WORD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I controller: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//
// Parameters:
//   MEM_TIMEOUT   cycles to wait for imem_gnt/dmem_gnt before FAULT (2..256)
//   RETIRE_CNT_W  width of the retired-instruction counter
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   instr                          instruction word held by the external IR
//   imem_gnt, dmem_gnt             memory handshakes
//   branch_taken                   branch comparator result (valid in EXEC)
//   imem_req, ir_we, pc_we, pc_sel fetch / IR / PC controls
//   op1_sel, op2_sel, alu_op       ALU operand and operation selects
//   rf_wr_data_sel, rf_wr_en       register-file write-back controls
//   dmem_req, dmem_wr_en,
//   dmem_size, dmem_zero_extend    data memory access controls
//   retire, retire_cnt             retire pulse and wrapping retire count
//   bus_fault                      sticky handshake-timeout flag
//   state_o                        current FSM state
//   illegal                        TRAP indication (ILLEGAL_TRAP_EN only)
//
// Configuration macro: ILLEGAL_TRAP_EN routes illegal encodings to a
// one-cycle TRAP state instead of executing them as ADDI-class ops.
module mc_control
    import risc_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             instr,
    input  logic                    imem_gnt,
    input  logic                    dmem_gnt,
    input  logic                    branch_taken,
    output logic                    imem_req,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    pc_sel,
    output logic                    op1_sel,
    output logic                    op2_sel,
    output alu_op_t                 alu_op,
    output wb_src_t                 rf_wr_data_sel,
    output logic                    rf_wr_en,
    output logic                    dmem_req,
    output logic                    dmem_wr_en,
    output logic                    dmem_zero_extend,
    output mem_size_t               dmem_size,
    output logic                    retire,
    output logic [RETIRE_CNT_W-1:0] retire_cnt,
    output logic                    bus_fault,
    output ctrl_state_t             state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                    illegal
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    decode_t          dec;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;

    mc_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    assign waiting = (state == S_FETCH && !imem_gnt) || (state == S_MEM && !dmem_gnt);
    // Grant is checked before timeout in the next-state logic, so a late
    // grant on the final allowed cycle still completes normally.
    assign timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign state_o = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            retire_cnt <= '0;
            bus_fault  <= 1'b0;
        end else begin
            state <= state_next;
            // Any state change clears the counter, covering entry to FETCH/MEM.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (state_next == S_FAULT) begin
                bus_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_gnt) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = dec.illegal ? S_TRAP : S_EXEC;
`else
                state_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                case (dec.cls)
                    CLS_LOAD, CLS_STORE: state_next = S_MEM;
                    CLS_BRANCH:          state_next = S_FETCH;
                    default:             state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_gnt) begin
                    state_next = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_next = S_FETCH;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req         = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = 1'b0;
        op1_sel          = 1'b0;
        op2_sel          = 1'b0;
        alu_op           = ALU_ADD;
        rf_wr_data_sel   = WB_ALU;
        rf_wr_en         = 1'b0;
        dmem_req         = 1'b0;
        dmem_wr_en       = 1'b0;
        dmem_zero_extend = 1'b0;
        dmem_size        = MEM_BYTE;
        retire           = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal          = 1'b0;
`endif

        // ALU selects stay valid through MEM (address) and WB (jump target).
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_op  = dec.alu_op;
            op1_sel = dec.op1_sel;
            op2_sel = dec.op2_sel;
        end

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_gnt;
            end
            S_EXEC: begin
                if (dec.cls == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req         = 1'b1;
                dmem_wr_en       = (dec.cls == CLS_STORE);
                dmem_size        = dec.size;
                dmem_zero_extend = dec.zero_ext;
                // A store completes in MEM itself, so its PC update and
                // retire strobe are qualified by the grant.
                if (dec.cls == CLS_STORE && dmem_gnt) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                rf_wr_en       = (dec.cls != CLS_STORE);
                rf_wr_data_sel = dec.wb_src;
                pc_we          = 1'b1;
                pc_sel         = (dec.cls == CLS_JUMP);
                retire         = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized
// legal RV32I instructions with random grant latencies, checked against an
// instruction-level reference model (class -> expected phase sequence).
module tb_mc_control;
  import risc_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  typedef enum int {K_ALU, K_JUMP, K_BR, K_LD, K_ST, K_BAD} kind_e;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       instr = 32'h0;
  logic              imem_gnt = 1'b0;
  logic              dmem_gnt = 1'b0;
  logic              branch_taken = 1'b0;
  logic              imem_req, ir_we, pc_we, pc_sel, op1_sel, op2_sel;
  alu_op_t           alu_op;
  wb_src_t           rf_wr_data_sel;
  logic              rf_wr_en, dmem_req, dmem_wr_en, dmem_zero_extend;
  mem_size_t         dmem_size;
  logic              retire;
  logic [CW-1:0]     retire_cnt;
  logic              bus_fault;
  ctrl_state_t       state_o;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  int                n_checks = 0;
  int                n_errors = 0;
  logic [CW-1:0]     exp_cnt = '0;

  always #5 clk = ~clk;

  mc_control #(.MEM_TIMEOUT(TO), .RETIRE_CNT_W(CW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .instr            (instr),
    .imem_gnt         (imem_gnt),
    .dmem_gnt         (dmem_gnt),
    .branch_taken     (branch_taken),
    .imem_req         (imem_req),
    .ir_we            (ir_we),
    .pc_we            (pc_we),
    .pc_sel           (pc_sel),
    .op1_sel          (op1_sel),
    .op2_sel          (op2_sel),
    .alu_op           (alu_op),
    .rf_wr_data_sel   (rf_wr_data_sel),
    .rf_wr_en         (rf_wr_en),
    .dmem_req         (dmem_req),
    .dmem_wr_en       (dmem_wr_en),
    .dmem_zero_extend (dmem_zero_extend),
    .dmem_size        (dmem_size),
    .retire           (retire),
    .retire_cnt       (retire_cnt),
    .bus_fault        (bus_fault),
    .state_o          (state_o)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal          (illegal)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (ISA level) ----------------
  function automatic kind_e kind_of(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_ALU : K_BAD;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_BAD;
        return K_ALU;
      end
      7'h37, 7'h17: return K_ALU;
      7'h6F, 7'h67: return K_JUMP;
      7'h63: return K_BR;
      7'h03: return K_LD;
      7'h23: return K_ST;
      default: return K_BAD;
    endcase
  endfunction

  function automatic alu_op_t exp_alu(input logic [31:0] ins);
    logic alt;
    if (kind_of(ins) == K_BAD) return ALU_ADD;
    if (ins[6:0] == 7'h37) return ALU_PASS_B;
    if (ins[6:0] != 7'h33 && ins[6:0] != 7'h13) return ALU_ADD;
    alt = ins[30] && (ins[14:12] == 3'd5 || ins[6:0] == 7'h33);
    case (ins[14:12])
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic exp_op1(input logic [31:0] ins);
    if (kind_of(ins) == K_BAD) return 1'b0;
    return (ins[6:0] == 7'h17 || ins[6:0] == 7'h6F || ins[6:0] == 7'h63);
  endfunction

  function automatic logic exp_op2(input logic [31:0] ins);
    return !(ins[6:0] == 7'h33 && kind_of(ins) == K_ALU);
  endfunction

  function automatic mem_size_t exp_size(input logic [31:0] ins);
    if (ins[13:12] == 2'd0) return MEM_BYTE;
    if (ins[13:12] == 2'd1) return MEM_HALF;
    return MEM_WORD;
  endfunction

  function automatic wb_src_t exp_wb(input kind_e k);
    if (k == K_LD) return WB_MEM;
    if (k == K_JUMP) return WB_PC4;
    return WB_ALU;
  endfunction

  function automatic logic [31:0] rand_instr();
    int          sel;
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    sel = int'($urandom_range(0, 8));
    r   = $urandom;
    f3  = r[14:12];
    case (sel)
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
        return {f7, r[24:15], f3, r[11:7], 7'h33};
      end
      1: begin
        if (f3 == 3'd1) f7 = 7'h00;
        else if (f3 == 3'd5) f7 = r[0] ? 7'h20 : 7'h00;
        else f7 = r[31:25];
        return {f7, r[24:15], f3, r[11:7], 7'h13};
      end
      2: return {r[31:7], 7'h37};
      3: return {r[31:7], 7'h17};
      4: return {r[31:7], 7'h6F};
      5: return {r[31:15], 3'd0, r[11:7], 7'h67};
      6: return {r[31:7], 7'h63};
      7: begin
        case (r[1:0])
          2'd0: f3 = 3'd2;
          2'd1: f3 = r[2] ? 3'd4 : 3'd0;
          2'd2: f3 = r[2] ? 3'd5 : 3'd1;
          default: f3 = 3'd2;
        endcase
        return {r[31:15], f3, r[11:7], 7'h03};
      end
      default: begin
        f3 = (r[1:0] == 2'd3) ? 3'd2 : {1'b0, r[1:0]};
        return {r[31:15], f3, r[11:7], 7'h23};
      end
    endcase
  endfunction

  // Starts at posedge+1 in the first FETCH cycle, ends likewise.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md, input logic tk);
    kind_e k;
    k = kind_of(ins);
    instr = ins;
    branch_taken = tk;
    for (int c = 0; c <= fd; c++) begin
      imem_gnt = (c == fd);
      @(negedge clk);
      check_eq("fetch_state", state_o, S_FETCH);
      check_eq("fetch_imem_req", imem_req, 1'b1);
      check_eq("fetch_ir_we", ir_we, (c == fd));
      @(posedge clk); #1;
    end
    imem_gnt = 1'b0;
    @(negedge clk);
    check_eq("decode_state", state_o, S_DECODE);
    check_eq("decode_retire", retire, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("exec_state", state_o, S_EXEC);
    check_eq("exec_alu_op", alu_op, exp_alu(ins));
    check_eq("exec_op1_sel", op1_sel, exp_op1(ins));
    check_eq("exec_op2_sel", op2_sel, exp_op2(ins));
    check_eq("exec_rf_wr_en", rf_wr_en, 1'b0);
    if (k == K_BR) begin
      check_eq("br_pc_we", pc_we, 1'b1);
      check_eq("br_pc_sel", pc_sel, tk);
      check_eq("br_retire", retire, 1'b1);
      exp_cnt = exp_cnt + 1'b1;
    end else begin
      check_eq("exec_retire", retire, 1'b0);
    end
    @(posedge clk); #1;
    if (k == K_LD || k == K_ST) begin
      for (int c = 0; c <= md; c++) begin
        dmem_gnt = (c == md);
        @(negedge clk);
        check_eq("mem_state", state_o, S_MEM);
        check_eq("mem_dmem_req", dmem_req, 1'b1);
        check_eq("mem_size", dmem_size, exp_size(ins));
        check_eq("mem_wr_en", dmem_wr_en, (k == K_ST));
        check_eq("mem_zext", dmem_zero_extend, (k == K_LD) && ins[14]);
        check_eq("mem_rf_wr_en", rf_wr_en, 1'b0);
        if (k == K_ST) begin
          check_eq("st_retire", retire, (c == md));
          check_eq("st_pc_we", pc_we, (c == md));
          check_eq("st_pc_sel", pc_sel, 1'b0);
        end else begin
          check_eq("ld_mem_retire", retire, 1'b0);
        end
        @(posedge clk); #1;
      end
      dmem_gnt = 1'b0;
      if (k == K_ST) exp_cnt = exp_cnt + 1'b1;
    end
    if (k != K_BR && k != K_ST) begin
      @(negedge clk);
      check_eq("wb_state", state_o, S_WB);
      check_eq("wb_rf_wr_en", rf_wr_en, 1'b1);
      check_eq("wb_pc_we", pc_we, 1'b1);
      check_eq("wb_retire", retire, 1'b1);
      check_eq("wb_pc_sel", pc_sel, (k == K_JUMP));
      check_eq("wb_src", rf_wr_data_sel, exp_wb(k));
      check_eq("wb_dmem_req", dmem_req, 1'b0);
      exp_cnt = exp_cnt + 1'b1;
      @(posedge clk); #1;
    end
    check_eq("end_state", state_o, S_FETCH);
    check_eq("retire_cnt", retire_cnt, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_imem_req"}, imem_req, 1'b0);
    check_eq({tag, "_pc_we"}, pc_we, 1'b0);
    check_eq({tag, "_dmem_req"}, dmem_req, 1'b0);
    check_eq({tag, "_rf_wr_en"}, rf_wr_en, 1'b0);
    check_eq({tag, "_retire"}, retire, 1'b0);
  endtask

  initial begin
    // ---------------- reset and first fetch ----------------
    #12;
    check_eq("rst_state", state_o, S_IDLE);
    check_eq("rst_retire_cnt", retire_cnt, 4'd0);
    check_eq("rst_bus_fault", bus_fault, 1'b0);
    check_all_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel_idle", state_o, S_IDLE);
    check_eq("rel_imem_req", imem_req, 1'b0);
    @(posedge clk); #1;
    check_eq("first_fetch", state_o, S_FETCH);
    check_eq("first_imem_req", imem_req, 1'b1);

    // ---------------- directed instructions ----------------
    run_instr(32'h00500093, 0, 0, 1'b0);
    run_instr(32'h0000A103, 0, 3, 1'b0);
    run_instr(32'h00000463, 0, 0, 1'b1);
    run_instr(32'h00500093, TO - 1, 0, 1'b0);

    // ---------------- randomized legal instructions ----------------
    for (int i = 0; i < 24; i++) begin
      run_instr(rand_instr(), int'($urandom_range(0, TO - 1)),
                int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)));
    end

    // ---------------- unsupported opcode ----------------
`ifdef ILLEGAL_TRAP_EN
    instr = 32'h0000007F;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("trap_state", state_o, S_TRAP);
    check_eq("trap_illegal", illegal, 1'b1);
    check_eq("trap_pc_we", pc_we, 1'b1);
    check_eq("trap_pc_sel", pc_sel, 1'b1);
    check_eq("trap_retire", retire, 1'b0);
    @(posedge clk); #1;
    check_eq("trap_exit", state_o, S_FETCH);
    check_eq("trap_retire_cnt", retire_cnt, exp_cnt);
`else
    run_instr(32'h0000007F, 0, 0, 1'b0);
`endif

    // ---------------- reset during a MEM wait ----------------
    instr = 32'h0000A103;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("midmem_state", state_o, S_MEM);
    check_eq("midmem_req", dmem_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("amem_rst_state", state_o, S_IDLE);
    check_eq("amem_rst_cnt", retire_cnt, 4'd0);
    check_all_zero("amem_rst");
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("amem_rel_idle", state_o, S_IDLE);
    @(posedge clk); #1;
    check_eq("amem_rel_fetch", state_o, S_FETCH);
    run_instr(32'h00500093, 1, 0, 1'b0);

    // ---------------- fetch timeout ----------------
    imem_gnt = 1'b0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      check_eq("to_fetch_state", state_o, S_FETCH);
      check_eq("to_imem_req", imem_req, 1'b1);
      check_eq("to_bus_fault_low", bus_fault, 1'b0);
      @(posedge clk); #1;
    end
    check_eq("fault_state", state_o, S_FAULT);
    check_eq("fault_flag", bus_fault, 1'b1);
    check_all_zero("fault");
    imem_gnt = 1'b1;
    dmem_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("fault_sticky_state", state_o, S_FAULT);
      check_eq("fault_sticky_flag", bus_fault, 1'b1);
      check_eq("fault_ir_we", ir_we, 1'b0);
    end
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("fault_rst_flag", bus_fault, 1'b0);
    check_eq("fault_rst_state", state_o, S_IDLE);
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_instr(32'h00000463, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
